// File: rtl/des_sbox_lanes.sv
// DES S-box substitution unit: LANES S-boxes time-multiplexed over 8/LANES cycles,
// with valid/ready handshakes on both sides and a sideband tag carried per word.
module des_sbox_lanes #(
  parameter int LANES = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int STEPS = 8 / LANES;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LW    = 4 * LANES;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("des_sbox_lanes: LANES must be 1, 2, 4 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("des_sbox_lanes: TAG_W must be at least 1");
    end
  endgenerate

  // Index 7 holds S1; each table lists entry (row*16 + col) from the MSB down.
  localparam logic [7:0][255:0] SBOX_TAB = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] grp);
    logic [255:0] tab;
    logic [5:0]   pos;
    logic [7:0]   base;
    tab  = SBOX_TAB[3'd7 - box];
    pos  = {grp[5], grp[0], grp[4:1]};
    base = 8'd255 - {pos, 2'b00};
    return tab[base -: 4];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [SW-1:0]    step_r;
  logic [47:0]      word_r;
  logic [TAG_W-1:0] tag_r;
  logic [31:0]      result_r;
  logic [2:0]       box_base_s;
  logic [LW-1:0]    lane_out_s;

  // Lane evaluation: the captured word is shifted so the next groups always sit at the top.
  always_comb begin
    box_base_s = 3'(int'(step_r) * LANES);
    lane_out_s = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_out_s[LW-1-4*j -: 4] = sbox_lookup(box_base_s + 3'(j), word_r[47-6*j -: 6]);
    end
  end

  // Control FSM and datapath registers; result nibbles shift in behind a cleared register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      step_r   <= '0;
      word_r   <= 48'd0;
      tag_r    <= '0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            word_r   <= in_data;
            tag_r    <= in_tag;
            result_r <= 32'd0;
            step_r   <= '0;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          word_r   <= word_r << (6 * LANES);
          result_r <= (result_r << LW) | 32'(lane_out_s);
          if (step_r == SW'(STEPS - 1)) begin
            step_r  <= '0;
            state_r <= DONE;
          end else begin
            step_r <= step_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              word_r   <= in_data;
              tag_r    <= in_tag;
              result_r <= 32'd0;
              step_r   <= '0;
              state_r  <= BUSY;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          step_r  <= '0;
        end
      endcase
    end
  end

  // Handshake outputs decoded from the registered state; out_ready reaches in_ready only in DONE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE: in_ready = 1'b1;
      BUSY: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign out_data = result_r;
  assign out_tag  = tag_r;

endmodule

// File: tb/tb_des_sbox_lanes.sv
// Self-checking bench for des_sbox_lanes: one instance per legal LANES value,
// known vectors, back-pressure, reset abort, streaming and a random handshake soak.
module tb_des_sbox_lanes;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid  [4];
  logic             in_ready  [4];
  logic [47:0]      in_data   [4];
  logic [TAG_W-1:0] in_tag    [4];
  logic             out_valid [4];
  logic             out_ready [4];
  logic [31:0]      out_data  [4];
  logic [TAG_W-1:0] out_tag   [4];
  logic             busy      [4];

  // Instance k runs with LANES = 2**k.
  for (genvar k = 0; k < 4; k++) begin : g_dut
    des_sbox_lanes #(.LANES(1 << k), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[k]), .in_ready(in_ready[k]), .in_data(in_data[k]), .in_tag(in_tag[k]),
      .out_valid(out_valid[k]), .out_ready(out_ready[k]), .out_data(out_data[k]),
      .out_tag(out_tag[k]), .busy(busy[k])
    );
  end

  // Reference DES S-boxes, row-major as printed in FIPS 46-3.
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] des_ref(input logic [47:0] d);
    logic [31:0] r;
    int g, row, col;
    r = 32'd0;
    for (int b = 0; b < 8; b++) begin
      g   = int'((d >> (42 - 6 * b)) & 48'd63);
      row = ((g / 32) % 2) * 2 + (g % 2);
      col = (g / 2) % 16;
      r   = (r << 4) | 32'(sb[b][row * 16 + col]);
    end
    return r;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Single word through instance k with out_ready high; checks latency, data and tag.
  task automatic run_one(input int k, input logic [47:0] d, input logic [3:0] t,
                         input logic [31:0] exp, input string name);
    int n;
    @(negedge clk);
    out_ready[k] = 1'b1; in_data[k] = d; in_tag[k] = t; in_valid[k] = 1'b1;
    #1;
    check({name, " in_ready"}, 64'(in_ready[k]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = ~d;
    n = 0;
    while (!out_valid[k] && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check({name, " latency"}, 64'(n), 64'(8 >> k));
    check({name, " data"}, 64'(out_data[k]), 64'(exp));
    check({name, " tag"}, 64'(out_tag[k]), 64'(t));
  endtask

  // Streams words through instance k against a queue-based scoreboard.
  task automatic run_stream(input int k, input int total, input bit rnd, input int max_cyc,
                            input string name);
    logic [51:0] expq[$];
    logic [51:0] e;
    int sent, got, cyc, last_out;
    logic prev_hold;
    logic [31:0] prev_d;
    logic [3:0] prev_t;
    sent = 0; got = 0; cyc = 0; last_out = -1; prev_hold = 1'b0; prev_d = '0; prev_t = '0;
    @(negedge clk);
    while (got < total && cyc < max_cyc) begin
      in_data[k] = {16'($urandom), 32'($urandom)};
      in_tag[k]  = 4'($urandom);
      if (rnd) begin
        in_valid[k]  = (sent < total) ? 1'($urandom_range(0, 1)) : 1'b0;
        out_ready[k] = 1'($urandom_range(0, 1));
      end else begin
        in_valid[k]  = (sent < total);
        out_ready[k] = 1'b1;
      end
      #1;
      if (prev_hold) begin
        check({name, " hold valid"}, 64'(out_valid[k]), 64'd1);
        check({name, " hold data"}, 64'(out_data[k]), 64'(prev_d));
        check({name, " hold tag"}, 64'(out_tag[k]), 64'(prev_t));
      end
      if (out_valid[k] && out_ready[k]) begin
        if (expq.size() == 0) begin
          check({name, " spurious output"}, 64'(out_data[k]), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check({name, " data"}, 64'(out_data[k]), 64'(des_ref(e[47:0])));
          check({name, " tag"}, 64'(out_tag[k]), 64'(e[51:48]));
        end
        if (!rnd && last_out >= 0) check({name, " spacing"}, 64'(cyc - last_out), 64'((8 >> k) + 1));
        last_out = cyc;
        got++;
      end
      prev_hold = out_valid[k] && !out_ready[k];
      prev_d = out_data[k];
      prev_t = out_tag[k];
      if (in_valid[k] && in_ready[k]) begin
        expq.push_back({in_tag[k], in_data[k]});
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    check({name, " words received"}, 64'(got), 64'(total));
    check({name, " pending"}, 64'(expq.size()), 64'd0);
  endtask

  typedef struct {
    int          k;
    logic [47:0] data;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  int soak_words [4] = '{200, 300, 400, 500};

  initial begin
    int n;
    logic bad;
    for (int k = 0; k < 4; k++) begin
      vecs[2*k]     = '{k, 48'h0000_0000_0000, 4'(k), 32'hEFA7_2C4D};
      vecs[2*k + 1] = '{k, 48'hFFFF_FFFF_FFFF, 4'(k + 8), 32'hD9CE_3DCB};
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = 48'd0; in_tag[k] = 4'd0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset in_ready L%0d", 1 << k), 64'(in_ready[k]), 64'd1);
      check($sformatf("reset out_valid L%0d", 1 << k), 64'(out_valid[k]), 64'd0);
      check($sformatf("reset busy L%0d", 1 << k), 64'(busy[k]), 64'd0);
      check($sformatf("reset out_data L%0d", 1 << k), 64'(out_data[k]), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].k, vecs[i].data, vecs[i].tag, vecs[i].exp,
              $sformatf("vec%0d L%0d", i, 1 << vecs[i].k));
    end

    // Back-pressure on LANES=2 with a competing input held valid.
    @(negedge clk);
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 48'h0; in_tag[1] = 4'h5;
    @(posedge clk);
    @(negedge clk);
    in_data[1] = 48'h1234_5678_9ABC; in_tag[1] = 4'hA;
    n = 0;
    while (!out_valid[1] && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("bp first valid", 64'(out_valid[1]), 64'd1);
    for (int c = 0; c < 10; c++) begin
      check("bp data", 64'(out_data[1]), 64'hEFA7_2C4D);
      check("bp tag", 64'(out_tag[1]), 64'h5);
      check("bp in_ready", 64'(in_ready[1]), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    #1;
    check("bp release in_ready", 64'(in_ready[1]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    check("bp retire valid", 64'(out_valid[1]), 64'd0);
    check("bp accept busy", 64'(busy[1]), 64'd1);
    n = 0;
    while (!out_valid[1] && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check("bp second data", 64'(out_data[1]), 64'(des_ref(48'h1234_5678_9ABC)));
    check("bp second tag", 64'(out_tag[1]), 64'hA);
    check("bp second latency", 64'(n), 64'd4);

    // Reset at step 4 of a LANES=1 word; it must never surface.
    @(negedge clk);
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 48'h0F0F_3C3C_A5A5; in_tag[0] = 4'h3;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst mid busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst in_ready", 64'(in_ready[0]), 64'd1);
    check("rst busy", 64'(busy[0]), 64'd0);
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid[0]) bad = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("rst no output", 64'(bad), 64'd0);
    run_one(0, 48'hFFFF_FFFF_FFFF, 4'h6, 32'hD9CE_3DCB, "rst next word");

    run_stream(2, 100, 1'b0, 1000, "stream L4");

    for (int k = 0; k < 4; k++) begin
      run_stream(k, soak_words[k], 1'b1, 5000, $sformatf("soak L%0d", 1 << k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
